// File: rtl/write_addr_gen_squeeze.sv
// Squeeze-kernel write address generator: streams kernel words into the kernel RAM,
// tracking fire-block wrap and per-layer word counts until the layer total is reached.
module write_addr_gen_squeeze #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              repeat_en_i,
  input  logic              repeat_flag_i,
  input  logic [11:0]       wr_addr_per_fire_i,
  input  logic [5:0]        wr_addr_per_layr_i,
  input  logic [6:0]        repeat_wr_addr_per_layr_i,
  input  logic [15:0]       tot_repeat_squ_kernals_i,
  input  logic [DATA_W-1:0] ker_data_i,
  input  logic              ker_valid_i,
  output logic              ker_ready_o,
  input  logic              ram_busy_i,
  output logic              wr_en_o,
  output logic [11:0]       wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              layr_done_o,
  output logic              fire_wrap_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              rep_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Limits latched in LOAD; both counters wrap when they equal their limit,
  // so a limit of N means N+1 words per fire block / per layer.
  logic [11:0] fire_lim;
  logic [6:0]  layr_lim;
  logic [15:0] layr_tot;

  logic [11:0] fire_cnt;
  logic [6:0]  word_cnt;
  logic [15:0] layr_cnt;

  logic accept;
  logic fire_last;
  logic word_last;
  logic final_layr;

  assign ker_ready_o = (state == WRITE) & ~ram_busy_i;
  assign accept      = ker_valid_i & ker_ready_o;
  assign fire_last   = (fire_cnt == fire_lim);
  assign word_last   = (word_cnt == layr_lim);
  assign final_layr  = (layr_cnt == (layr_tot - 16'd1));

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  // NOTE: state register uses non-blocking assignment so every flop samples
  // the pre-edge value; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = LOAD;
      // The total being latched this cycle decides the exit, so use the live config.
      LOAD:  state_nxt = (tot_repeat_squ_kernals_i == 16'd0) ? DONE : WRITE;
      WRITE: if (accept && word_last && final_layr) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration latch and the three counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fire_lim <= '0;
      layr_lim <= '0;
      layr_tot <= '0;
      rep_o    <= 1'b0;
      fire_cnt <= '0;
      word_cnt <= '0;
      layr_cnt <= '0;
    end else if (state == LOAD) begin
      fire_lim <= wr_addr_per_fire_i;
      layr_lim <= repeat_en_i ? repeat_wr_addr_per_layr_i : {1'b0, wr_addr_per_layr_i};
      layr_tot <= tot_repeat_squ_kernals_i;
      rep_o    <= repeat_flag_i;
      fire_cnt <= '0;
      word_cnt <= '0;
      layr_cnt <= '0;
    end else if (accept) begin
      fire_cnt <= fire_last ? 12'd0 : fire_cnt + 12'd1;
      if (word_last) begin
        word_cnt <= '0;
        layr_cnt <= layr_cnt + 16'd1;
      end else begin
        word_cnt <= word_cnt + 7'd1;
      end
    end
  end

  // RAM write port: one-cycle latency; address and data hold between writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      fire_wrap_o <= 1'b0;
      layr_done_o <= 1'b0;
    end else begin
      wr_en_o     <= accept;
      fire_wrap_o <= accept & fire_last;
      layr_done_o <= accept & word_last;
      if (accept) begin
        wr_addr_o <= fire_cnt;
        wr_data_o <= ker_data_i;
      end
    end
  end

endmodule
